// File: rtl/scurve_pkg.sv
// Shared definitions for the S-curve measurement blocks: state encoding,
// count width, trigger synchronizer depth and a saturating increment helper.
package scurve_pkg;

    // Width of trigger/pulse counts and of the FIFO data word.
    localparam int CNT_W      = 16;
    // Flip-flop stages in the trigger synchronizer; the controller's word
    // format assumes this depth as well.
    localparam int SYNC_DEPTH = 2;

    typedef enum logic [2:0] {
        IDLE,
        PULSE_HI,
        PULSE_LO,
        WR_TRIG,
        WR_CPT,
        DONE
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/trig_sync_edge.sv
// Brings an asynchronous trigger into the clock domain through a
// SYNC_DEPTH-stage synchronizer and emits a registered one-cycle pulse on
// each rising edge. Input-to-pulse latency is SYNC_DEPTH + 1 cycles.
module trig_sync_edge
    import scurve_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic [SYNC_DEPTH-1:0] sync_d;
    logic                  prev_q;
    logic                  rise_q;

    // Each stage samples the previous one; stage 0 samples the raw input.
    for (genvar gi = 0; gi < SYNC_DEPTH; gi++) begin : g_sync
        if (gi == 0) begin : g_first
            assign sync_d[gi] = async_i;
        end else begin : g_rest
            assign sync_d[gi] = sync_q[gi-1];
        end
    end

    // Synchronizer chain, previous-level register and edge pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[SYNC_DEPTH-1];
            rise_q <= sync_q[SYNC_DEPTH-1] & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/scurve_single_test.sv
// One S-curve measurement point: fires CPT_MAX CTest pulses, counts returned
// discriminator triggers, then writes {trigger count, pulse count} to the
// S-curve data FIFO and strobes Single_Test_Done.
// Optional feature macro: SCURVE_TRIG_WINDOW_EN -- when defined, a trigger is
// only counted inside the first TRIG_WINDOW cycles of each injection period,
// and at most once per pulse.
module scurve_single_test
    import scurve_pkg::*;
#(
    parameter int CPT_MAX      = 1000,
    parameter int PULSE_PERIOD = 1000,
    parameter int PULSE_WIDTH  = 10,
    parameter int TRIG_WINDOW  = 100
) (
    input  logic             Clk,
    input  logic             reset_n,
    input  logic             Single_Test_Start,
    output logic             Single_Test_Done,
    output logic             CTest_Pulse,
    input  logic             Trigger_In,
    input  logic             SCurve_Data_fifo_full,
    output logic             SCurve_Data_fifo_wr_en,
    output logic [CNT_W-1:0] SCurve_Data_fifo_din,
    output logic             Busy
);

`ifdef SCURVE_TRIG_WINDOW_EN
    localparam bit WIN_EN = 1'b1;
`else
    localparam bit WIN_EN = 1'b0;
`endif

    // The final period is stretched by the trigger path latency so that a
    // trigger arriving at the very end of it still reaches the counter.
    localparam int          TAIL       = SYNC_DEPTH + 1;
    localparam logic [31:0] HI_LAST    = 32'(PULSE_WIDTH - 1);
    localparam logic [31:0] LO_LAST    = 32'(PULSE_PERIOD - 1);
    localparam logic [31:0] FINAL_LAST = 32'(PULSE_PERIOD - 1 + TAIL);
    localparam logic [31:0] WIN_LEN    = 32'(TRIG_WINDOW);
    localparam logic [CNT_W-1:0] CPT_LAST = CNT_W'(CPT_MAX);

    state_t           state_q, state_d;
    logic [31:0]      cyc_q, cyc_d;          // cycles since current pulse rose
    logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [CNT_W-1:0] trig_cnt_q, trig_cnt_d;
    logic             hit_q, hit_d;          // a trigger already counted this pulse
    logic             ctest_q;
    logic             trig_rise;
    logic             in_pulse;
    logic             count_ok;

    trig_sync_edge u_trig (
        .clk     (Clk),
        .rst_n   (reset_n),
        .async_i (Trigger_In),
        .rise_o  (trig_rise)
    );

    // State, counters and the registered CTest output.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cyc_q       <= '0;
            pulse_cnt_q <= '0;
            trig_cnt_q  <= '0;
            hit_q       <= 1'b0;
            ctest_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            pulse_cnt_q <= pulse_cnt_d;
            trig_cnt_q  <= trig_cnt_d;
            hit_q       <= hit_d;
            ctest_q     <= (state_d == PULSE_HI);
        end
    end

    assign in_pulse = (state_q == PULSE_HI) || (state_q == PULSE_LO);
    assign count_ok = trig_rise && in_pulse &&
                      (!WIN_EN || ((cyc_q < WIN_LEN) && !hit_q));

    // Next-state, counter updates and FIFO handshake.
    always_comb begin
        state_d                = state_q;
        cyc_d                  = cyc_q;
        pulse_cnt_d            = pulse_cnt_q;
        trig_cnt_d             = trig_cnt_q;
        hit_d                  = hit_q;
        SCurve_Data_fifo_wr_en = 1'b0;
        SCurve_Data_fifo_din   = '0;
        Single_Test_Done       = 1'b0;

        if (count_ok) begin
            trig_cnt_d = sat_inc(trig_cnt_q);
            hit_d      = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (Single_Test_Start) begin
                    state_d     = PULSE_HI;
                    cyc_d       = '0;
                    pulse_cnt_d = CNT_W'(1);
                    trig_cnt_d  = '0;
                    hit_d       = 1'b0;
                end
            end
            PULSE_HI: begin
                cyc_d = cyc_q + 32'd1;
                if (cyc_q == HI_LAST) begin
                    state_d = PULSE_LO;
                end
            end
            PULSE_LO: begin
                cyc_d = cyc_q + 32'd1;
                if (pulse_cnt_q == CPT_LAST) begin
                    if (cyc_q == FINAL_LAST) begin
                        state_d = WR_TRIG;
                    end
                end else if (cyc_q == LO_LAST) begin
                    state_d     = PULSE_HI;
                    cyc_d       = '0;
                    pulse_cnt_d = sat_inc(pulse_cnt_q);
                    hit_d       = 1'b0;
                end
            end
            WR_TRIG: begin
                SCurve_Data_fifo_din = trig_cnt_q;
                if (!SCurve_Data_fifo_full) begin
                    SCurve_Data_fifo_wr_en = 1'b1;
                    state_d                = WR_CPT;
                end
            end
            WR_CPT: begin
                SCurve_Data_fifo_din = pulse_cnt_q;
                if (!SCurve_Data_fifo_full) begin
                    SCurve_Data_fifo_wr_en = 1'b1;
                    state_d                = DONE;
                end
            end
            DONE: begin
                Single_Test_Done = 1'b1;
                state_d          = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign CTest_Pulse = ctest_q;
    assign Busy        = (state_q != IDLE);

endmodule
